// File: rtl/vector_frame_source_if.sv
// Output stream of the vector frame source: one operand row per beat with frame markers.
interface vector_frame_source_if #(
    parameter int unsigned DATA_W = 128
);
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_first;
    logic              out_last;
    logic              out_ready;

    modport master (
        output out_data,
        output out_valid,
        output out_first,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_first,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/vector_frame_source.sv
// Producer for the adder-tree/accumulator: stores operand rows and replays them
// as framed bursts (first/last markers, optional idle gap between frames).
module vector_frame_source #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned GAP    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en_i,
    input  logic [ADDR_W-1:0]     wr_addr_i,
    input  logic [DATA_W-1:0]     wr_data_i,
    input  logic                  start_i,
    input  logic [ADDR_W:0]       frame_len_i,
    input  logic [7:0]            num_frames_i,
    vector_frame_source_if.master out_if,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int unsigned LEN_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   row_q, row_d;
    logic [ADDR_W-1:0]   last_row_q, last_row_d;
    logic [7:0]          frames_q, frames_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                first_q, first_d;
    logic                last_q, last_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                wr_ok_c;
    logic [DATA_W-1:0]   row0_c;
    logic [ADDR_W-1:0]   next_row_c;
    logic [LEN_W-1:0]    len_c;
    logic [ADDR_W-1:0]   eff_last_c;

    assign wr_ok_c    = wr_en_i & ~busy_q;
    // A write to row 0 in the start cycle must already appear on the first beat.
    assign row0_c     = (wr_ok_c && (wr_addr_i == '0)) ? wr_data_i : mem_q[0];
    assign next_row_c = ADDR_W'(row_q + 1'b1);
    assign len_c      = ((frame_len_i == '0) || (frame_len_i > LEN_W'(DEPTH)))
                        ? LEN_W'(DEPTH) : frame_len_i;
    assign eff_last_c = ADDR_W'(len_c - 1'b1);

    // Row register file; intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_ok_c) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            row_q      <= '0;
            last_row_q <= '0;
            frames_q   <= '0;
            gap_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            last_row_q <= last_row_d;
            frames_q   <= frames_d;
            gap_q      <= gap_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            first_q    <= first_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next state; every beat register holds by default, which implements the stall.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        last_row_d = last_row_q;
        frames_d   = frames_q;
        gap_d      = gap_q;
        data_d     = data_q;
        first_d    = first_q;
        last_d     = last_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    last_row_d = eff_last_c;
                    frames_d   = num_frames_i;
                    row_d      = '0;
                    if (num_frames_i == 8'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SEND;
                        data_d  = row0_c;
                        first_d = 1'b1;
                        last_d  = (eff_last_c == '0);
                    end
                end
            end
            S_SEND: begin
                if (out_if.out_ready) begin
                    if (row_q == last_row_q) begin
                        frames_d = frames_q - 8'd1;
                        row_d    = '0;
                        if (frames_q == 8'd1) begin
                            state_d = S_DONE;
                        end else if (GAP == 0) begin
                            data_d  = row0_c;
                            first_d = 1'b1;
                            last_d  = (last_row_q == '0);
                        end else begin
                            state_d = S_GAP;
                            gap_d   = GAP_W'(GAP - 1);
                        end
                    end else begin
                        row_d   = next_row_c;
                        data_d  = mem_q[next_row_c];
                        first_d = 1'b0;
                        last_d  = (next_row_c == last_row_q);
                    end
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_SEND;
                    data_d  = row0_c;
                    first_d = 1'b1;
                    last_d  = (last_row_q == '0);
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d != S_SEND) begin
            first_d = 1'b0;
            last_d  = 1'b0;
        end
        valid_d = (state_d == S_SEND);
        busy_d  = (state_d == S_SEND) || (state_d == S_GAP);
        done_d  = (state_d == S_DONE);
    end

    assign out_if.out_data  = data_q;
    assign out_if.out_valid = valid_q;
    assign out_if.out_first = first_q;
    assign out_if.out_last  = last_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;

endmodule
